// File: rtl/pc_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_stage
//  Purpose  : Instruction-fetch stage. Owns the PC, drives the instruction
//             memory address, loads IF/ID, and handles EX-stage redirects
//             (with squash, redirect counting and a sticky bad-target halt).
//  Revision : 1.0  initial release
// ============================================================================
module pc_fetch_stage #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            pc_sel,
    input  logic [31:0]     br_pc,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] ifid_pc,
    output logic [31:0]     ifid_instr,
    output logic            ifid_valid,
    output logic            flush_idex,
    output logic            fetch_err,
    output logic [15:0]     redirect_cnt
);

    localparam logic [0:0]      S_RUN     = 1'b0;
    localparam logic [0:0]      S_HALT    = 1'b1;
    localparam logic [PC_W-1:0] c_PC_STEP = PC_W'(4);
    localparam logic [15:0]     c_CNT_MAX = 16'hFFFF;

    logic [0:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_ifid_pc;
    logic [31:0]     r_ifid_instr;
    logic            r_ifid_valid;
    logic            r_fetch_err;
    logic [15:0]     r_redirect_cnt;

    logic [0:0]      w_state_nxt;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_ifid_pc_nxt;
    logic [31:0]     w_ifid_instr_nxt;
    logic            w_ifid_valid_nxt;
    logic            w_fetch_err_nxt;
    logic [15:0]     w_redirect_cnt_nxt;
    logic            w_target_ok;

    // A target is usable only if word aligned and representable in PC_W bits.
    assign w_target_ok = (br_pc[1:0] == 2'b00) && ((br_pc >> PC_W) == 32'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_pc_nxt           = r_pc;
        w_ifid_pc_nxt      = r_ifid_pc;
        w_ifid_instr_nxt   = r_ifid_instr;
        w_ifid_valid_nxt   = r_ifid_valid;
        w_fetch_err_nxt    = r_fetch_err;
        w_redirect_cnt_nxt = r_redirect_cnt;
        case (r_state)
            S_RUN: begin
                if (pc_sel) begin
                    // The IF slot is wrong-path whether or not the target is usable.
                    w_ifid_pc_nxt    = '0;
                    w_ifid_instr_nxt = NOP;
                    w_ifid_valid_nxt = 1'b0;
                    if (w_target_ok) begin
                        w_pc_nxt = br_pc[PC_W-1:0];
                        if (r_redirect_cnt != c_CNT_MAX) begin
                            w_redirect_cnt_nxt = r_redirect_cnt + 16'd1;
                        end
                    end else begin
                        w_fetch_err_nxt = 1'b1;
                        w_state_nxt     = S_HALT;
                    end
                end else if (!stall) begin
                    w_pc_nxt         = r_pc + c_PC_STEP;
                    w_ifid_pc_nxt    = r_pc;
                    w_ifid_instr_nxt = imem_rdata;
                    w_ifid_valid_nxt = 1'b1;
                end
            end
            S_HALT: begin
                w_ifid_instr_nxt = NOP;
                w_ifid_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc           <= RESET_PC;
            r_ifid_pc      <= '0;
            r_ifid_instr   <= NOP;
            r_ifid_valid   <= 1'b0;
            r_fetch_err    <= 1'b0;
            r_redirect_cnt <= '0;
        end else begin
            r_pc           <= w_pc_nxt;
            r_ifid_pc      <= w_ifid_pc_nxt;
            r_ifid_instr   <= w_ifid_instr_nxt;
            r_ifid_valid   <= w_ifid_valid_nxt;
            r_fetch_err    <= w_fetch_err_nxt;
            r_redirect_cnt <= w_redirect_cnt_nxt;
        end
    end

    assign imem_addr    = r_pc;
    assign flush_idex   = pc_sel;
    assign ifid_pc      = r_ifid_pc;
    assign ifid_instr   = r_ifid_instr;
    assign ifid_valid   = r_ifid_valid;
    assign fetch_err    = r_fetch_err;
    assign redirect_cnt = r_redirect_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_stage
//  Purpose  : Self-checking bench for pc_fetch_stage: directed scenarios plus
//             randomized traffic against a cycle-level behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_stage;

    localparam logic [31:0] NOP_T = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        pc_sel = 1'b0;
    logic [31:0] br_pc = '0;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [8:0]  ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        flush_idex;
    logic        fetch_err;
    logic [15:0] redirect_cnt;

    logic [31:0] mem [0:127];

    // Behavioural model of the architecturally visible state.
    logic [8:0]  m_pc;
    logic [8:0]  m_ifid_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_err;
    logic [15:0] m_cnt;
    logic        m_halt;
    logic        obs_flush;

    int total = 0;
    int bad   = 0;

    pc_fetch_stage #(.PC_W(9), .RESET_PC(9'd0), .NOP(NOP_T)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .pc_sel       (pc_sel),
        .br_pc        (br_pc),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .ifid_pc      (ifid_pc),
        .ifid_instr   (ifid_instr),
        .ifid_valid   (ifid_valid),
        .flush_idex   (flush_idex),
        .fetch_err    (fetch_err),
        .redirect_cnt (redirect_cnt)
    );

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[8:2]];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired (actual=running required=finished)");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus; advances the model and leaves time at posedge+1.
    task automatic step(input bit rs, input bit st, input bit ps, input logic [31:0] bp);
        bit good;
        @(negedge clk);
        reset  = rs;
        stall  = st;
        pc_sel = ps;
        br_pc  = bp;
        #1;
        obs_flush = flush_idex;
        good = (bp % 4 == 0) && (bp < 32'd512);
        if (rs) begin
            m_pc = 9'd0; m_ifid_pc = 9'd0; m_instr = NOP_T; m_valid = 1'b0;
            m_err = 1'b0; m_cnt = 16'd0; m_halt = 1'b0;
        end else if (m_halt) begin
            m_valid = 1'b0; m_instr = NOP_T;
        end else if (ps) begin
            m_valid = 1'b0; m_instr = NOP_T; m_ifid_pc = 9'd0;
            if (good) begin
                m_pc = bp[8:0];
                if (m_cnt < 16'd65535) m_cnt = m_cnt + 16'd1;
            end else begin
                m_err = 1'b1; m_halt = 1'b1;
            end
        end else if (!st) begin
            m_ifid_pc = m_pc;
            m_instr   = mem[m_pc / 4];
            m_valid   = 1'b1;
            m_pc      = m_pc + 9'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1, 0, 0, 0);
        total++; if (imem_addr !== 9'd0) begin bad++; $display("FAIL reset_addr actual=%h required=%h", imem_addr, 9'd0); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL reset_valid actual=%b required=0", ifid_valid); end
        total++; if (ifid_instr !== NOP_T) begin bad++; $display("FAIL reset_instr actual=%h required=%h", ifid_instr, NOP_T); end
        total++; if (ifid_pc !== 9'd0) begin bad++; $display("FAIL reset_ifid_pc actual=%h required=0", ifid_pc); end
        total++; if ({fetch_err, redirect_cnt} !== 17'd0) begin bad++; $display("FAIL reset_err_cnt actual=%b/%h required=0/0", fetch_err, redirect_cnt); end
    endtask

    task automatic test_sequential;
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 0);
            total++;
            if (imem_addr !== 9'(4 * i) || ifid_pc !== 9'(4 * (i - 1)) || ifid_valid !== 1'b1 ||
                ifid_instr !== mem[i - 1] || redirect_cnt !== 16'd0) begin
                bad++;
                $display("FAIL seq_fetch[%0d] actual addr=%h ifid_pc=%h v=%b instr=%h cnt=%0d required addr=%h ifid_pc=%h v=1 instr=%h cnt=0",
                         i, imem_addr, ifid_pc, ifid_valid, ifid_instr, redirect_cnt, 9'(4 * i), 9'(4 * (i - 1)), mem[i - 1]);
            end
        end
    endtask

    task automatic test_branch;
        total++; if (imem_addr !== 9'h010) begin bad++; $display("FAIL branch_start actual=%h required=010", imem_addr); end
        step(0, 0, 1, 32'h0000_0040);
        total++; if (obs_flush !== 1'b1) begin bad++; $display("FAIL branch_flush actual=%b required=1", obs_flush); end
        total++;
        if (imem_addr !== 9'h040 || ifid_valid !== 1'b0 || ifid_instr !== NOP_T || redirect_cnt !== 16'd1) begin
            bad++;
            $display("FAIL branch_redirect actual addr=%h v=%b instr=%h cnt=%0d required addr=040 v=0 instr=%h cnt=1",
                     imem_addr, ifid_valid, ifid_instr, redirect_cnt, NOP_T);
        end
        step(0, 0, 0, 0);
        total++;
        if (ifid_pc !== 9'h040 || ifid_valid !== 1'b1 || ifid_instr !== mem[16] || imem_addr !== 9'h044) begin
            bad++;
            $display("FAIL branch_target_fetch actual ifid_pc=%h v=%b instr=%h addr=%h required ifid_pc=040 v=1 instr=%h addr=044",
                     ifid_pc, ifid_valid, ifid_instr, imem_addr, mem[16]);
        end
    endtask

    task automatic test_stall_redirect;
        step(0, 0, 1, 32'h0000_001C);
        step(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 0);
            total++;
            if (imem_addr !== 9'h020 || ifid_pc !== 9'h01C || ifid_valid !== 1'b1 || ifid_instr !== mem[7]) begin
                bad++;
                $display("FAIL stall_hold[%0d] actual addr=%h ifid_pc=%h v=%b instr=%h required addr=020 ifid_pc=01c v=1 instr=%h",
                         i, imem_addr, ifid_pc, ifid_valid, ifid_instr, mem[7]);
            end
        end
        step(0, 1, 1, 32'h0000_0100);
        total++;
        if (obs_flush !== 1'b1 || imem_addr !== 9'h100 || ifid_valid !== 1'b0 || redirect_cnt !== 16'd3) begin
            bad++;
            $display("FAIL stall_redirect actual flush=%b addr=%h v=%b cnt=%0d required flush=1 addr=100 v=0 cnt=3",
                     obs_flush, imem_addr, ifid_valid, redirect_cnt);
        end
        step(0, 0, 0, 0);
        total++; if (ifid_pc !== 9'h100 || ifid_valid !== 1'b1) begin bad++; $display("FAIL stall_resume actual ifid_pc=%h v=%b required 100/1", ifid_pc, ifid_valid); end
    endtask

    task automatic test_wrap;
        step(0, 0, 1, 32'h0000_01FC);
        total++; if (imem_addr !== 9'h1FC) begin bad++; $display("FAIL wrap_target actual=%h required=1fc", imem_addr); end
        step(0, 0, 0, 0);
        total++;
        if (imem_addr !== 9'h000 || ifid_pc !== 9'h1FC || fetch_err !== 1'b0) begin
            bad++;
            $display("FAIL wrap_increment actual addr=%h ifid_pc=%h err=%b required addr=000 ifid_pc=1fc err=0", imem_addr, ifid_pc, fetch_err);
        end
        step(0, 0, 0, 0);
        total++; if (imem_addr !== 9'h004 || fetch_err !== 1'b0) begin bad++; $display("FAIL wrap_after actual addr=%h err=%b required 004/0", imem_addr, fetch_err); end
    endtask

    task automatic test_bad_target;
        logic [8:0]  held_pc;
        logic [15:0] held_cnt;
        logic [31:0] targets [0:1];
        bit          ps;
        targets[0] = 32'h0000_0042;
        targets[1] = 32'h0000_0200;
        for (int t = 0; t < 2; t++) begin
            step(0, 0, 0, 0);
            held_pc  = imem_addr;
            held_cnt = redirect_cnt;
            step(0, 0, 1, targets[t]);
            total++;
            if (obs_flush !== 1'b1 || fetch_err !== 1'b1 || imem_addr !== held_pc || ifid_valid !== 1'b0 ||
                ifid_instr !== NOP_T || redirect_cnt !== held_cnt) begin
                bad++;
                $display("FAIL bad_target[%h] actual flush=%b err=%b addr=%h v=%b instr=%h cnt=%0d required flush=1 err=1 addr=%h v=0 instr=%h cnt=%0d",
                         targets[t], obs_flush, fetch_err, imem_addr, ifid_valid, ifid_instr, redirect_cnt, held_pc, NOP_T, held_cnt);
            end
            for (int i = 0; i < 6; i++) begin
                ps = (i % 2 == 0);
                step(0, $urandom_range(0, 1) == 1, ps, 32'h0000_0080);
                total++;
                if (fetch_err !== 1'b1 || ifid_valid !== 1'b0 || imem_addr !== held_pc ||
                    redirect_cnt !== held_cnt || obs_flush !== ps) begin
                    bad++;
                    $display("FAIL halt_sticky[%0d] actual err=%b v=%b addr=%h cnt=%0d flush=%b required err=1 v=0 addr=%h cnt=%0d flush=%b",
                             i, fetch_err, ifid_valid, imem_addr, redirect_cnt, obs_flush, held_pc, held_cnt, ps);
                end
            end
            step(1, 0, 0, 0);
            total++; if (fetch_err !== 1'b0 || imem_addr !== 9'd0) begin bad++; $display("FAIL halt_reset actual err=%b addr=%h required 0/000", fetch_err, imem_addr); end
        end
        step(0, 0, 1, 32'h0000_0080);
        step(1, 0, 1, 32'h0000_0088);
        total++;
        if (imem_addr !== 9'd0 || redirect_cnt !== 16'd0 || ifid_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_redirect actual addr=%h cnt=%0d v=%b required 000/0/0", imem_addr, redirect_cnt, ifid_valid);
        end
    endtask

    task automatic test_random;
        bit          rs, st, ps;
        logic [31:0] bp;
        for (int i = 0; i < 400; i++) begin
            rs = ($urandom_range(0, 99) < 2);
            st = ($urandom_range(0, 99) < 30);
            ps = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 99) < 8) bp = $urandom;
            else                           bp = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
            step(rs, st, ps, bp);
            total++;
            if ({imem_addr, ifid_pc, ifid_instr, ifid_valid, fetch_err, redirect_cnt, obs_flush} !==
                {m_pc, m_ifid_pc, m_instr, m_valid, m_err, m_cnt, ps}) begin
                bad++;
                $display("FAIL random[%0d] actual addr=%h ifid_pc=%h instr=%h v=%b err=%b cnt=%0d flush=%b required addr=%h ifid_pc=%h instr=%h v=%b err=%b cnt=%0d flush=%b",
                         i, imem_addr, ifid_pc, ifid_instr, ifid_valid, fetch_err, redirect_cnt, obs_flush,
                         m_pc, m_ifid_pc, m_instr, m_valid, m_err, m_cnt, ps);
            end
        end
    endtask

    task automatic test_saturation;
        step(1, 0, 0, 0);
        for (int i = 1; i <= 65540; i++) begin
            step(0, 0, 1, {23'd0, 7'(i), 2'b00});
            if (i == 65534 || i == 65535 || i == 65536) begin
                total++;
                if (redirect_cnt !== m_cnt) begin
                    bad++;
                    $display("FAIL sat_count[%0d] actual=%h required=%h", i, redirect_cnt, m_cnt);
                end
            end
        end
        total++; if (redirect_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_final actual=%h required=ffff", redirect_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        m_pc = 9'd0; m_ifid_pc = 9'd0; m_instr = NOP_T; m_valid = 1'b0;
        m_err = 1'b0; m_cnt = 16'd0; m_halt = 1'b0; obs_flush = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_stall_redirect();
        test_wrap();
        test_bad_target();
        test_random();
        test_saturation();
        @(negedge clk);
        pc_sel = 1'b0;
        stall  = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_stage.md
# pc_fetch_stage

Instruction-fetch stage of the 5-stage pipeline: holds the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register. It sits directly downstream of the EX-stage branch unit and consumes its taken-redirect flag and target. On a taken redirect it reloads the PC, squashes the wrong-path instructions in IF and ID, and counts redirects. A misaligned or out-of-range target stops fetch in a sticky error state.

## Interface
Parameters:
- PC_W, 9, PC / instruction-memory byte-address width (matches the 9-bit current PC fed to the branch unit)
- RESET_PC, 0, PC value loaded on reset
- NOP, 32'h0000_0013, encoding placed in IF/ID when the slot is invalid (addi x0,x0,0)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hazard-unit stall; holds the PC and IF/ID
- pc_sel  in  1  branch unit: branch/jal/jalr taken
- br_pc  in  32  branch unit: redirect target
- imem_addr  out  PC_W  instruction-memory address, combinational copy of the PC register
- imem_rdata  in  32  instruction word at imem_addr, valid in the same cycle
- ifid_pc  out  PC_W  PC of the instruction held in IF/ID
- ifid_instr  out  32  instruction held in IF/ID
- ifid_valid  out  1  IF/ID holds a real instruction
- flush_idex  out  1  combinational; squash the instruction moving ID->EX this edge
- fetch_err  out  1  sticky: a bad redirect target was seen
- redirect_cnt  out  16  number of taken redirects, saturating

## Operation
- FSM with 2 states: RUN and HALT. Reset enters RUN.
- RUN, priority from highest to lowest:
  - **Redirect** (pc_sel=1):
    - If the target is good (br_pc[1:0]==0 and br_pc[31:PC_W]==0): pc <= br_pc[PC_W-1:0]; ifid_valid <= 0; ifid_instr <= NOP; ifid_pc <= 0; redirect_cnt += 1, saturating at 16'hFFFF.
    - If the target is bad: fetch_err <= 1; state <= HALT; the PC holds; IF/ID is flushed the same way as for a good target; the counter does not change.
    - A redirect overrides stall.
  - **Stall** (pc_sel=0, stall=1): PC and all IF/ID outputs hold.
  - **Normal**: pc <= pc + 4, modulo 2^PC_W; ifid_pc <= pc; ifid_instr <= imem_rdata; ifid_valid <= 1.
- HALT:
  - The PC holds.
  - Every edge: ifid_valid <= 0, ifid_instr <= NOP.
  - pc_sel and stall are ignored. Only reset leaves HALT.
- flush_idex = pc_sel in RUN and in HALT, independent of stall and of target validity.
  - The instruction in ID at the time of the redirect is wrong-path.
  - The downstream ID/EX register must bubble it.
- Width rules:
  - pc[1:0] is always 0.
  - Increment wraps: pc = 2^PC_W-4 increments to 0, and the wrap is not an error.
  - Only the low PC_W bits of br_pc are loaded.

## Timing
- Reset values (registered, visible in the cycle after the reset edge):
  - pc/imem_addr = RESET_PC
  - ifid_pc = 0, ifid_instr = NOP, ifid_valid = 0
  - fetch_err = 0, redirect_cnt = 0, state = RUN
- Reset asserted mid-redirect or while in HALT wins over everything else.
- Fetch latency:
  - The instruction at address A is on imem_addr in cycle n.
  - It appears in IF/ID (ifid_valid=1) in cycle n+1.
- Redirect penalty:
  - pc_sel=1 in cycle n gives imem_addr = target in n+1.
  - The target instruction is valid in IF/ID in n+2.
  - Two slots are squashed: the ID instruction via flush_idex in cycle n, and the IF instruction via ifid_valid=0 in n+1.
- Back-to-back redirects in consecutive cycles are each honoured and each counted.
- stall held for k cycles freezes imem_addr and IF/ID for exactly k cycles. Fetch resumes on the first cycle with stall=0.
- Outputs other than imem_addr and flush_idex change only on a rising clk edge.

## Test plan
- **Reset and sequential fetch:** reset 1 cycle, then stall=0, pc_sel=0 for 4 cycles.
  - imem_addr goes 0, 4, 8, 12.
  - ifid_pc lags by one cycle: 0, 4, 8.
  - ifid_valid=0 in the first cycle after reset, then 1.
  - redirect_cnt=0.
- **Taken branch:** at pc=0x010, pulse pc_sel=1 with br_pc=0x0000_0040.
  - flush_idex=1 in that cycle.
  - Next cycle: imem_addr=0x040, ifid_valid=0, ifid_instr=0x00000013.
  - Cycle after: ifid_pc=0x040, ifid_valid=1.
  - redirect_cnt=1.
- **Stall vs redirect:** stall=1 for 3 cycles at pc=0x020.
  - imem_addr stays 0x020 and IF/ID is frozen.
  - In the 3rd stall cycle also assert pc_sel with br_pc=0x100: next imem_addr=0x100.
- **Wrap-around:** redirect to 0x1FC with PC_W=9, then run 2 cycles.
  - imem_addr goes 0x1FC, then 0x000.
  - fetch_err stays 0.
- **Bad target:** pc_sel=1 with br_pc=0x0000_0042, then separately with br_pc=0x0000_0200.
  - fetch_err=1 and the PC holds.
  - ifid_valid stays 0 in every later cycle, including across later pc_sel pulses.
  - redirect_cnt is unchanged.
  - reset clears fetch_err to 0 and imem_addr to 0.
- **Counter saturation:** force 65 536 consecutive good redirects.
  - redirect_cnt stops at 16'hFFFF and does not wrap.
